// File: rtl/qspi_bridge_pkg.sv
// Shared types for qspi_mem_bridge: FSM states, request size codes,
// default address width and the size -> last-byte-index helper.
package qspi_bridge_pkg;

    localparam int DEF_ADDR_W = 25;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RD,
        WR,
        STOP,
        HOLD
    } state_t;

    // Size code 3 behaves as a word.
    function automatic logic [1:0] last_idx(input logic [1:0] size);
        unique case (size)
            SIZE_B:  return 2'd0;
            SIZE_H:  return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/qspi_mem_bridge.sv
// qspi_mem_bridge: CPU word/half/byte requests -> byte-serial qspi_controller txns.
// Define QSPI_SEQ_READ_EN to keep a finished read open (HOLD) for sequential reads.
module qspi_mem_bridge
    import qspi_bridge_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] qc_addr,
    output logic [7:0]        qc_wbyte,
    output logic              qc_start_read,
    output logic              qc_start_write,
    output logic              qc_stall_txn,
    output logic              qc_stop_txn,
    input  logic [7:0]        qc_rbyte,
    input  logic              qc_data_ready,
    input  logic              qc_data_req,
    input  logic              qc_busy
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_last;
    logic [1:0]        r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rd;
    logic              r_pend;
    logic              r_rsp;

    logic              w_req;
    logic              w_load;
    logic              w_seq;
    logic              w_replay;
    logic              w_at_last;
    logic              w_rd_byte;
    logic              w_wr_step;
    logic [2:0]        w_sel;

`ifdef QSPI_SEQ_READ_EN
    logic [ADDR_W-1:0] r_next;
    logic              w_match;

    assign w_match = req_read && (req_addr == r_next)
                     && (req_addr[ADDR_W-1 -: 2] == r_addr[ADDR_W-1 -: 2]);
`endif

    assign w_req     = req_read | req_write;
    assign w_at_last = (r_idx == r_last);
    assign w_rd_byte = (r_state == RD) && qc_data_ready;
    assign w_wr_step = (r_state == WR) && qc_data_req;

    // The controller takes the current byte when it raises data_req,
    // so the following byte must already be on the bus in that cycle.
    assign w_sel    = {1'b0, r_idx} + {2'b00, qc_data_req};
    assign qc_wbyte = 8'(r_wdata >> {w_sel, 3'b000});

    assign qc_addr   = r_addr;
    assign rsp_valid = r_rsp;
    assign rsp_rdata = r_rdata;

    always_comb begin
        w_next         = r_state;
        req_ready      = 1'b0;
        qc_start_read  = 1'b0;
        qc_start_write = 1'b0;
        qc_stall_txn   = 1'b0;
        qc_stop_txn    = 1'b0;
        w_load         = 1'b0;
        w_seq          = 1'b0;
        w_replay       = 1'b0;
        unique case (r_state)
            IDLE: begin
                req_ready = !qc_busy && !r_pend;
                if (r_pend && !qc_busy) begin
                    w_replay = 1'b1;
                    w_next   = START;
                end else if (req_ready && w_req) begin
                    w_load = 1'b1;
                    w_next = START;
                end
            end
            START: begin
                if (qc_busy) begin
                    w_next = r_rd ? RD : WR;
                end else begin
                    qc_start_read  = r_rd;
                    qc_start_write = !r_rd;
                end
            end
            RD: begin
                qc_stall_txn = w_at_last;
                if (qc_data_ready && w_at_last) begin
`ifdef QSPI_SEQ_READ_EN
                    w_next = HOLD;
`else
                    w_next = STOP;
`endif
                end
            end
            WR: begin
                if (qc_data_req && w_at_last) w_next = STOP;
            end
            STOP: begin
                qc_stop_txn = 1'b1;
                if (!qc_busy) w_next = IDLE;
            end
`ifdef QSPI_SEQ_READ_EN
            HOLD: begin
                qc_stall_txn = 1'b1;
                req_ready    = 1'b1;
                if (w_req) begin
                    w_load = 1'b1;
                    if (w_match) begin
                        w_seq  = 1'b1;
                        w_next = RD;
                    end else begin
                        w_next = STOP;
                    end
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_last  <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rd    <= 1'b0;
            r_pend  <= 1'b0;
            r_rsp   <= 1'b0;
        end else begin
            r_rsp <= 1'b0;
            if (w_load) begin
                r_addr  <= req_addr;
                r_last  <= last_idx(req_size);
                r_wdata <= req_wdata;
                r_rd    <= req_read;
                r_rdata <= '0;
                r_idx   <= '0;
                // A non-sequential request taken in HOLD is replayed after STOP.
                r_pend  <= (r_state == HOLD) && !w_seq;
            end else if (w_replay) begin
                r_pend <= 1'b0;
            end
            if (w_rd_byte) begin
                r_rdata[{r_idx, 3'b000} +: 8] <= qc_rbyte;
                r_idx <= w_at_last ? 2'd0 : r_idx + 2'd1;
                r_rsp <= w_at_last;
            end
            if (w_wr_step) begin
                r_idx <= w_at_last ? 2'd0 : r_idx + 2'd1;
            end
            if ((r_state == STOP) && !qc_busy && !r_rd && !r_pend) begin
                r_rsp <= 1'b1;
            end
        end
    end

`ifdef QSPI_SEQ_READ_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_next <= '0;
        end else if (w_rd_byte && w_at_last) begin
            r_next <= r_addr + ADDR_W'(r_last) + ADDR_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_qspi_mem_bridge.sv
// Self-checking bench for qspi_mem_bridge with a behavioural qspi_controller
// stand-in and a byte-array reference memory.
`timescale 1ns/1ps
module tb_qspi_mem_bridge;

`ifdef QSPI_SEQ_READ_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [24:0] req_addr;
    logic [1:0]  req_size;
    logic        req_read;
    logic        req_write;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [24:0] qc_addr;
    logic [7:0]  qc_wbyte;
    logic        qc_start_read;
    logic        qc_start_write;
    logic        qc_stall_txn;
    logic        qc_stop_txn;
    logic [7:0]  qc_rbyte;
    logic        qc_data_ready;
    logic        qc_data_req;
    logic        qc_busy;

    always #5 clk = ~clk;

    qspi_mem_bridge dut (
        .clk           (clk),
        .rstn          (rstn),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .qc_addr       (qc_addr),
        .qc_wbyte      (qc_wbyte),
        .qc_start_read (qc_start_read),
        .qc_start_write(qc_start_write),
        .qc_stall_txn  (qc_stall_txn),
        .qc_stop_txn   (qc_stop_txn),
        .qc_rbyte      (qc_rbyte),
        .qc_data_ready (qc_data_ready),
        .qc_data_req   (qc_data_req),
        .qc_busy       (qc_busy)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Device contents: controller side (cmem) and reference side (rmem).
    logic [7:0] cmem [logic [24:0]];
    logic [7:0] rmem [logic [24:0]];

    function automatic logic [7:0] pat(input logic [24:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[24]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] cread(input logic [24:0] a);
        return cmem.exists(a) ? cmem[a] : pat(a);
    endfunction

    function automatic logic [7:0] rread(input logic [24:0] a);
        return rmem.exists(a) ? rmem[a] : pat(a);
    endfunction

    function automatic logic [24:0] waddr(input logic [24:0] a, input int k);
        return {a[24], 24'(a[23:0] + 24'(k))};
    endfunction

    // Controller stand-in: refuses starts during RAM reselect spacing,
    // paces bytes with gaps, holds the next byte while stalled.
    logic [24:0] m_addr;
    logic        m_rd;
    logic        m_pause;
    int          m_k;
    int          m_gap;
    int          m_stopc;
    int          m_cool;
    int          n_starts = 0;
    int          n_sr = 0;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            qc_busy       <= 1'b0;
            qc_data_ready <= 1'b0;
            qc_data_req   <= 1'b0;
            qc_rbyte      <= 8'h00;
            m_addr        <= '0;
            m_rd          <= 1'b0;
            m_pause       <= 1'b0;
            m_k           <= 0;
            m_gap         <= 0;
            m_stopc       <= 0;
            m_cool        <= 0;
        end else begin
            qc_data_ready <= 1'b0;
            qc_data_req   <= 1'b0;
            if (!qc_busy) begin
                if (m_cool > 0) begin
                    m_cool <= m_cool - 1;
                end else if (qc_start_read || qc_start_write) begin
                    qc_busy  <= 1'b1;
                    m_rd     <= qc_start_read;
                    m_addr   <= qc_addr;
                    m_k      <= 0;
                    m_pause  <= 1'b0;
                    m_stopc  <= 0;
                    m_gap    <= int'($urandom_range(1, 3));
                    n_starts <= n_starts + 1;
                end
            end else if (qc_stop_txn) begin
                if (m_stopc == 1) begin
                    qc_busy <= 1'b0;
                    m_cool  <= m_addr[24] ? 6 : 0;
                end
                m_stopc <= (m_stopc == 0) ? int'($urandom_range(1, 3)) : m_stopc - 1;
            end else if (m_pause) begin
                if (!qc_stall_txn) begin
                    m_pause <= 1'b0;
                    m_gap   <= 1;
                end
            end else if (m_gap > 0) begin
                m_gap <= m_gap - 1;
            end else begin
                m_gap <= int'($urandom_range(1, 2));
                m_k   <= m_k + 1;
                if (m_rd) begin
                    qc_data_ready <= 1'b1;
                    qc_rbyte      <= cread(waddr(m_addr, m_k));
                    if (qc_stall_txn) m_pause <= 1'b1;
                end else begin
                    qc_data_req <= 1'b1;
                    cmem[waddr(m_addr, m_k)] = qc_wbyte;
                end
            end
        end
    end

    always @(negedge clk) if (qc_start_read) n_sr <= n_sr + 1;

    task automatic chk_rst(input string tag);
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_ctl"}, 32'({rsp_valid, qc_start_read, qc_start_write,
                                qc_stall_txn, qc_stop_txn}), 32'd0);
        chk({tag, "_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_addr"}, 32'(qc_addr), 32'd0);
        chk({tag, "_wbyte"}, 32'(qc_wbyte), 32'd0);
    endtask

    task automatic do_req(input logic [24:0] a, input logic [1:0] sz, input logic rd,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] rdat);
        int n;
        int to;
        int ndr;
        int nrq;
        logic prev_dr;
        logic got;
        logic [31:0] exp;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        exp = '0;
        rdat = '0;
        for (int k = 0; k < n; k++) begin
            if (rd) exp[8*k +: 8] = rread(a + 25'(k));
            else    rmem[a + 25'(k)] = wd[8*k +: 8];
        end
        @(negedge clk);
        to = 0;
        while (!req_ready && to < 200) begin
            @(negedge clk);
            to++;
        end
        if (!req_ready) begin
            chk({tag, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        req_addr  = a;
        req_size  = sz;
        req_read  = rd;
        req_write = !rd;
        req_wdata = wd;
        @(negedge clk);
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 25'($urandom);
        req_wdata = $urandom;
        ndr = 0;
        nrq = 0;
        prev_dr = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                ndr += int'(qc_data_ready);
                nrq += int'(qc_data_req);
                prev_dr = qc_data_ready;
                @(negedge clk);
            end
        end
        if (!got) begin
            chk({tag, "_rsp_timeout"}, 32'd0, 32'd1);
            return;
        end
        rdat = rsp_rdata;
        if (rd) begin
            chk({tag, "_data"}, rsp_rdata, exp);
            chk({tag, "_lat"}, 32'(ndr * 2 + int'(prev_dr)), 32'(n * 2 + 1));
        end else begin
            chk({tag, "_nreq"}, 32'(nrq), 32'(n));
            for (int k = 0; k < n; k++)
                chk({tag, "_mem"}, 32'(cread(a + 25'(k))), 32'(wd[8*k +: 8]));
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [31:0] rdat;
    logic [24:0] a;
    logic [24:0] nxt;
    logic [1:0]  sz;
    logic        rd;
    logic        prev_rd;
    int          s0;
    int          to;

    initial begin
        req_addr  = '0;
        req_size  = '0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk_rst("reset");
        rstn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            cmem[25'h100 + 25'(k)] = 8'(8'h11 * (k + 1));
            rmem[25'h100 + 25'(k)] = 8'(8'h11 * (k + 1));
        end
        do_req(25'h000100, 2'd2, 1'b1, 32'h0, "t1", rdat);
        chk("t1_word", rdat, 32'h44332211);
        chk("t1_stop", 32'(qc_stop_txn), 32'(!SEQ));

        do_req(25'h1000004, 2'd0, 1'b0, 32'h000000A5, "t2", rdat);
        chk("t2_ramA", 32'(cread(25'h1000004)), 32'hA5);

        do_req(25'h1000020, 2'd2, 1'b0, 32'hCAFEF00D, "t3w", rdat);
        s0 = n_sr;
        do_req(25'h1000020, 2'd2, 1'b1, 32'h0, "t3r", rdat);
        chk("t3_word", rdat, 32'hCAFEF00D);
        chk("t3_held", 32'(n_sr - s0 > 1), 32'd1);

        do_req(25'h000010, 2'd1, 1'b1, 32'h0, "t4a", rdat);
        s0 = n_starts;
        do_req(25'h000012, 2'd2, 1'b1, 32'h0, "t4b", rdat);
        chk("t4_word", rdat, {pat(25'h15), pat(25'h14), pat(25'h13), pat(25'h12)});
        chk("t4_starts", 32'(n_starts - s0), 32'(!SEQ));

        do_req(25'h000010, 2'd1, 1'b1, 32'h0, "t5a", rdat);
        s0 = n_starts;
        do_req(25'h000020, 2'd2, 1'b1, 32'h0, "t5b", rdat);
        chk("t5_starts", 32'(n_starts - s0), 32'd1);

        // Reset in the middle of a read.
        repeat (20) @(negedge clk);
        to = 0;
        while (!req_ready && to < 200) begin
            @(negedge clk);
            to++;
        end
        req_addr = 25'h000040;
        req_size = 2'd2;
        req_read = 1'b1;
        @(negedge clk);
        req_read = 1'b0;
        to = 0;
        while (!qc_data_ready && to < 100) begin
            @(negedge clk);
            to++;
        end
        chk("t6_in_rd", 32'(qc_data_ready), 32'd1);
        #2 rstn = 1'b0;
        #1 chk_rst("t6_rst");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        do_req(25'h000040, 2'd2, 1'b1, 32'h0, "t6r", rdat);

        prev_rd = 1'b0;
        nxt = '0;
        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            if (rd && prev_rd && $urandom_range(0, 2) == 0)
                a = nxt;
            else if (rd && $urandom_range(0, 1) == 0)
                a = {1'b0, 16'h0000, 8'($urandom)};
            else
                a = {1'b1, 1'($urandom), 15'h0000, 8'($urandom)};
            if (SEQ && rd && prev_rd && a == nxt && sz == 2'd0) sz = 2'd1;
            do_req(a, sz, rd, $urandom, $sformatf("rnd%0d", i), rdat);
            prev_rd = rd;
            nxt = a + ((sz == 2'd0) ? 25'd1 : (sz == 2'd1) ? 25'd2 : 25'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
